ring_code_decoder: RTL and testbench
====================================

# ring_code_decoder

Receive-side companion to the 4-bit ring counter. Samples a one-hot ring code on a strobe, decodes it to a binary index, checks that each code is the expected rotation of the previous one, and reports lock status plus illegal-code and sequence errors. Sits wherever a ring-counter output crosses into logic that needs a binary position or a health indication.

## Interface
- WIDTH, 4: ring width in bits, ≥2
- LOCK_CNT, 3: consecutive correct rotations required to declare lock, ≥1
- DIR, 0: expected rotation; 0 = toward MSB (0001→0010→…→1000→0001), 1 = toward LSB
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ring_in  in  WIDTH  ring code to check
- in_valid  in  1  sample strobe; ring_in is ignored when low
- index  out  IW=$clog2(WIDTH)  binary position of the set bit in the last legal sample
- index_valid  out  1  high for one cycle after each legal sample
- locked  out  1  sequence locked
- code_err  out  1  one-cycle pulse: sampled code not one-hot (zero or ≥2 bits set)
- seq_err  out  1  one-cycle pulse: legal code that is not the expected rotation
- err_cnt  out  8  saturating error count (see Configuration)

## Operation
- Legal code: exactly one bit set. Expected code: prev_code rotated by one position per DIR, wrapping MSB↔LSB.
- States: SEARCH, TRACK, LOCKED. match_cnt counts 0..LOCK_CNT.
- SEARCH: legal sample → store prev_code, match_cnt=0, go to TRACK. Illegal sample → code_err, stay in SEARCH.
- TRACK: expected sample → match_cnt+1; when it reaches LOCK_CNT, go to LOCKED. Legal but unexpected sample (including a repeat of prev_code) → seq_err, store new code, match_cnt=0, stay in TRACK. Illegal sample → code_err, go to SEARCH.
- LOCKED: expected sample → stay. Legal but unexpected sample → seq_err, store code, match_cnt=0, go to TRACK. Illegal sample → code_err, go to SEARCH.
- in_valid=0: state, prev_code, match_cnt and index hold; no pulses; index_valid=0.
- code_err and seq_err are mutually exclusive by construction.
- locked = (state == LOCKED).

## Timing
- All outputs registered. One-cycle latency from a sample to index, index_valid, code_err, seq_err, and the locked change.
- On an illegal sample, index holds its old value and index_valid=0.
- Back-to-back in_valid is supported every cycle. Gaps of any length are tolerated.
- Reset values: index=0, index_valid=0, locked=0, code_err=0, seq_err=0, err_cnt=0, state=SEARCH, prev_code=0, match_cnt=0.
- rst has priority over in_valid. Reset mid-lock takes effect on the next edge, and the sample in that cycle is discarded.

## Configuration
- RING_DEC_ERRCNT_EN defined: err_cnt increments on every code_err or seq_err pulse cycle and saturates at 255. Only rst clears it.
- Not defined: counter logic is absent and err_cnt is tied to 0. The port is kept so the interface stays stable.

## Structure
- Package ring_pkg: state enum (SEARCH, TRACK, LOCKED), ERR_CNT_W=8, and a rotate function parameterised by DIR.
- Sub-module onehot_to_bin (combinational, WIDTH parameter). Outputs the binary index and a legal flag; shared with future ring-code users.
- Top level contains the FSM, match counter, output registers and the optional error counter.

## Test plan
Defaults WIDTH=4, LOCK_CNT=3, DIR=0, macro defined.
- Hold rst=1 for 2 cycles with in_valid=1 and ring_in=0011 → every output 0; no err pulse; err_cnt=0.
- Samples 0001,0010,0100,1000,0001, one per cycle → index 0,1,2,3,0 one cycle later with index_valid=1 each time. locked rises the cycle after 1000 and stays high through the wrap to 0001.
- While locked, sample 0110 → code_err for 1 cycle, index_valid=0, locked=0, err_cnt=1. Then 0100 → TRACK, index=2.
- Locked at 0010, then sample 1000 → seq_err for 1 cycle, index=3, locked=0. Then 0001,0010,0100 → locked returns the cycle after 0100.
- Locked sequence with 1–5 cycle in_valid=0 gaps between samples → locked stays high, no err pulses, index_valid only after strobes.
- 300 consecutive samples of 0000 → code_err each cycle and err_cnt saturates at 255. A following rst → err_cnt=0. Rebuild without the macro → err_cnt stays 0.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for ring-code logic: FSM state encoding,
// error-counter width and a one-position ring rotation.
package ring_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_t;

    // Rotate a width-bit code by one position; dir=0 toward MSB, dir=1 toward LSB.
    function automatic logic [31:0] rotate(input logic [31:0] code, input int width, input logic dir);
        logic [31:0] mask;
        mask = {32{1'b1}} >> (32 - width);
        if (!dir)
            rotate = ((code << 1) | (code >> (width - 1))) & mask;
        else
            rotate = ((code >> 1) | (code << (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder with legality flag (exactly one bit set).
// Combinational, zero latency; no flow control.
module onehot_to_bin #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic [IW-1:0]    index,
    output logic             legal
);

    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (code[i])
                index = index | IW'(i);
        end
    end

    assign legal = (code != '0) && ((code & (code - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_code_decoder.sv
// Ring-code receiver: decodes, checks rotation order, reports lock and error pulses.
// One-cycle registered latency; no backpressure, samples accepted on every in_valid.
// Optional saturating error counter enabled by RING_DEC_ERRCNT_EN.
module ring_code_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int DIR      = 0,
    parameter int IW       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 in_valid,
    output logic [IW-1:0]        index,
    output logic                 index_valid,
    output logic                 locked,
    output logic                 code_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    ring_state_t      state;
    logic [WIDTH-1:0] prev_code;
    logic [MW-1:0]    match_cnt;

    logic [IW-1:0]    dec_index;
    logic             dec_legal;
    logic [WIDTH-1:0] expected;
    logic [MW-1:0]    match_nxt;
    logic             is_expected;
    logic             code_err_nxt;
    logic             seq_err_nxt;

    onehot_to_bin #(.WIDTH(WIDTH), .IW(IW)) u_dec (
        .code  (ring_in),
        .index (dec_index),
        .legal (dec_legal)
    );

    assign expected     = WIDTH'(rotate(32'(prev_code), WIDTH, DIR != 0));
    assign is_expected  = (ring_in == expected);
    assign match_nxt    = match_cnt + MW'(1);
    assign code_err_nxt = in_valid && !dec_legal;
    assign seq_err_nxt  = in_valid && dec_legal && (state != SEARCH) && !is_expected;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            prev_code   <= '0;
            match_cnt   <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            locked      <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            index_valid <= 1'b0;
            code_err    <= code_err_nxt;
            seq_err     <= seq_err_nxt;
            if (in_valid) begin
                if (!dec_legal) begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end else begin
                    index       <= dec_index;
                    index_valid <= 1'b1;
                    prev_code   <= ring_in;
                    case (state)
                        SEARCH: begin
                            match_cnt <= '0;
                            state     <= TRACK;
                        end
                        TRACK: begin
                            if (is_expected) begin
                                match_cnt <= match_nxt;
                                if (match_nxt == MW'(LOCK_CNT)) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!is_expected) begin
                                match_cnt <= '0;
                                state     <= TRACK;
                                locked    <= 1'b0;
                            end
                        end
                        default: begin
                            match_cnt <= '0;
                            state     <= SEARCH;
                            locked    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef RING_DEC_ERRCNT_EN
    // Counts in step with the pulse registers so err_cnt and the pulse appear together.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if ((code_err_nxt || seq_err_nxt) && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_code_decoder.sv
// Randomised self-checking bench for ring_code_decoder against a position-based model.
module tb_ring_code_decoder;

    localparam int W  = 4;
    localparam int LC = 3;
    localparam int D  = 0;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  ring_in = '0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] index;
    logic          index_valid, locked, code_err, seq_err;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;

    // model state: 0 search, 1 track, 2 locked; position of last legal code
    int m_state = 0, m_pos = 0, m_match = 0, m_index = 0;
    int m_iv = 0, m_ce = 0, m_se = 0, m_err = 0;
    int gen_pos = 0;

    ring_code_decoder #(.WIDTH(W), .LOCK_CNT(LC), .DIR(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .ring_in     (ring_in),
        .in_valid    (in_valid),
        .index       (index),
        .index_valid (index_valid),
        .locked      (locked),
        .code_err    (code_err),
        .seq_err     (seq_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int position(input logic [W-1:0] c);
        for (int i = 0; i < W; i++)
            if (c[i]) return i;
        return 0;
    endfunction

    task automatic model(input logic r, input logic v, input logic [W-1:0] c);
        int p, nxt;
        if (r) begin
            m_state = 0; m_pos = 0; m_match = 0; m_index = 0;
            m_iv = 0; m_ce = 0; m_se = 0; m_err = 0;
            return;
        end
        m_iv = 0; m_ce = 0; m_se = 0;
        if (!v) return;
        if ($countones(c) != 1) begin
            m_ce = 1;
            m_state = 0;
            if (m_err < 255) m_err++;
            return;
        end
        p = position(c);
        m_index = p;
        m_iv = 1;
        if (m_state == 0) begin
            m_pos = p; m_match = 0; m_state = 1;
            return;
        end
        nxt = (D == 0) ? (m_pos + 1) % W : (m_pos + W - 1) % W;
        if (p == nxt) begin
            m_pos = p;
            if (m_state == 1) begin
                m_match++;
                if (m_match == LC) m_state = 2;
            end
        end else begin
            m_se = 1;
            if (m_err < 255) m_err++;
            m_pos = p; m_match = 0; m_state = 1;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] c);
        int exp_err;
        rst = r; in_valid = v; ring_in = c;
        @(posedge clk);
        model(r, v, c);
        #1;
`ifdef RING_DEC_ERRCNT_EN
        exp_err = m_err;
`else
        exp_err = 0;
`endif
        chk("index", int'(index), m_index);
        chk("index_valid", int'(index_valid), m_iv);
        chk("locked", int'(locked), (m_state == 2) ? 1 : 0);
        chk("code_err", int'(code_err), m_ce);
        chk("seq_err", int'(seq_err), m_se);
        chk("err_cnt", int'(err_cnt), exp_err);
    endtask

    task automatic send(input int c);
        step(1'b0, 1'b1, W'(c));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        // reset with an illegal sample present
        step(1'b1, 1'b1, 4'b0011);
        step(1'b1, 1'b1, 4'b0011);

        // lock on a full rotation and wrap
        send(1); send(2); send(4); send(8); send(1);
        // illegal while locked, then relock
        send(6); send(4); send(8); send(1); send(2);
        // out-of-order while locked
        send(8); send(1); send(2); send(4);
        // locked with gaps
        for (int i = 0; i < 8; i++) begin
            gap(int'($urandom_range(1, 5)));
            send(1 << ((3 + i) % W));
        end
        // repeat of prev_code is a sequence error
        send(4); send(4);

        // reset mid-lock discards the sample
        send(8); send(1); send(2); send(4);
        step(1'b1, 1'b1, 4'b1000);
        send(2);

        // randomised traffic
        gen_pos = 1;
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                gap(1);
            end else if (r < 15) begin
                send(int'($urandom_range(0, (1 << W) - 1)));
            end else if (r < 20) begin
                gen_pos = int'($urandom_range(0, W - 1));
                send(1 << gen_pos);
            end else begin
                gen_pos = (D == 0) ? (gen_pos + 1) % W : (gen_pos + W - 1) % W;
                send(1 << gen_pos);
            end
        end

        // saturation, then reset clears the counter
        for (int i = 0; i < 300; i++)
            send(0);
        step(1'b1, 1'b0, '0);
        send(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
